cpsr_update: RTL and testbench
==============================

// Module: cpsr_update
// PURPOSE
//  Owns the CPSR register and writes the NZCV flags that the condition evaluator reads.
//  Takes ALU/shifter results of the EX-stage instruction and captures new flags in a pending slot.
//  Commits the pending slot one cycle later and handles MSR writes.
//  Drives a forwarded CPSR view so a dependent instruction sees flags with zero bubbles.
// PARAMETERS
//  RESET_CPSR  32'h0000_0000  value loaded into committed CPSR on reset
//  FWD_EN      1              1: cpsr = pending view when pending; 0: cpsr = committed only
// PORTS
//  clk            in   1   rising-edge clock
//  rst_b          in   1   asynchronous active-low reset
//  ex_valid       in   1   EX-stage instruction valid
//  ex_set_cond    in   1   EX instruction writes flags (gated cond_go && S-bit && data-proc)
//  ex_is_logical  in   1   logical op: C from shifter, V preserved
//  alu_result     in   32  EX ALU result
//  alu_carry      in   1   adder carry-out
//  alu_overflow   in   1   adder signed overflow
//  shifter_carry  in   1   barrel-shifter carry-out
//  msr_valid      in   1   EX instruction is MSR to CPSR
//  msr_data       in   32  MSR source value
//  msr_mask       in   4   byte-field enables; bit i writes cpsr[8i+7:8i]
//  stall          in   1   pipeline freeze
//  flush          in   1   squash EX-stage instruction this cycle
//  cpsr           out  32  forwarded CPSR view, fed to condition evaluation
//  cpsr_committed out  32  architectural CPSR
//  flags_pending  out  1   pending slot holds an uncommitted update
// BEHAVIOUR
//  Flag bits: N=31, Z=30, C=29, V=28.
//  Reset (async, rst_b=0): committed=RESET_CPSR, pending slot cleared, state EMPTY.
//   Outputs: cpsr=cpsr_committed=RESET_CPSR, flags_pending=0.
//  Forwarded view F = (state==PENDING && FWD_EN) ? pend_val : committed. cpsr=F, combinational.
//  Capture condition cap = ex_valid && !flush && (ex_set_cond || msr_valid).
//  Flag value: N=alu_result[31]; Z=(alu_result==0).
//   C = ex_is_logical ? shifter_carry : alu_carry.
//   V = ex_is_logical ? F[28] : alu_overflow.
//   Other bits come from F.
//  MSR value: for each byte i, msr_mask[i] ? msr_data byte i : F byte i.
//   msr_valid wins over ex_set_cond when both are set.
//  States: EMPTY, PENDING. Each rising edge:
//   stall=1: hold state, committed and pend_val; no capture, no commit (stall overrides all).
//   else PENDING: committed <= pend_val (flush does not cancel an older pending commit).
//   else if cap: pend_val <= new value, next state PENDING.
//   else: next state EMPTY.
//  Back-to-back writers: the commit of the older update and the capture of the newer happen
//   in the same cycle. The newer value is built from F, so it already includes the older one.
//  Latency: capture to visible on cpsr 1 cycle (FWD_EN=1); to cpsr_committed 2 cycles.
//  flags_pending = (state==PENDING). ex_* with ex_valid=0 are ignored.
//  Reset mid-operation discards the pending update; it is never committed.
// TESTING
//  1 reset: rst_b=0 while PENDING -> cpsr=cpsr_committed=RESET_CPSR, flags_pending=0 immediately.
//  2 ADDS res=0, carry=1, ovf=0 -> +1 cyc cpsr[31:28]=0110, pending=1;
//    +2 cyc cpsr_committed[31:28]=0110, pending=0.
//  3 SUBS res=32'h8000_0000 ovf=1, then ANDS logical res=1 shc=0 next cycle -> after 2nd, NZCV=0001.
//  4 ex_valid=1, ex_set_cond=1, flush=1 -> no capture, cpsr unchanged; a prior pending still commits.
//  5 pending + stall=1 for 3 cycles -> cpsr, cpsr_committed, flags_pending frozen; commit after release.
//  6 MSR mask=1000 data=32'hF000_00AA over cpsr=0 -> +2 cyc cpsr_committed=32'hF000_0000.
//  7 FWD_EN=0: ADDS res=0 -> cpsr tracks cpsr_committed, Z visible only after 2 cycles.

Source files
------------

// File: rtl/cpsr_update_if.sv
// EX-stage flag/MSR request bundle and CPSR views for cpsr_update.
// master: drives EX-stage inputs, slave: the CPSR owner.
interface cpsr_update_if;
    logic        ex_valid;
    logic        ex_set_cond;
    logic        ex_is_logical;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic        alu_overflow;
    logic        shifter_carry;
    logic        msr_valid;
    logic [31:0] msr_data;
    logic [3:0]  msr_mask;
    logic        stall;
    logic        flush;
    logic [31:0] cpsr;
    logic [31:0] cpsr_committed;
    logic        flags_pending;

    modport master (
        output ex_valid, ex_set_cond, ex_is_logical,
        output alu_result, alu_carry, alu_overflow, shifter_carry,
        output msr_valid, msr_data, msr_mask,
        output stall, flush,
        input  cpsr, cpsr_committed, flags_pending
    );

    modport slave (
        input  ex_valid, ex_set_cond, ex_is_logical,
        input  alu_result, alu_carry, alu_overflow, shifter_carry,
        input  msr_valid, msr_data, msr_mask,
        input  stall, flush,
        output cpsr, cpsr_committed, flags_pending
    );
endinterface

// File: rtl/cpsr_update.sv
// CPSR owner: captures NZCV / MSR updates into a pending slot, commits next cycle.
// Ports: clk, rst_b (async active-low), bus (cpsr_update_if.slave).
module cpsr_update #(
    parameter logic [31:0] RESET_CPSR = 32'h0000_0000,
    parameter bit          FWD_EN     = 1'b1
) (
    input logic          clk,
    input logic          rst_b,
    cpsr_update_if.slave bus
);
    typedef enum logic {
        EMPTY,
        PENDING
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] comm_q, comm_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] fwd;
    logic [31:0] flag_val;
    logic [31:0] msr_val;
    logic [31:0] new_val;
    logic        cap;

    // New values are built on the forwarded view so back-to-back
    // writers chain through the still-uncommitted older update.
    always_comb begin
        fwd = comm_q;
        if (state_q == PENDING && FWD_EN)
            fwd = pend_q;
    end

    always_comb begin
        flag_val        = fwd;
        flag_val[31]    = bus.alu_result[31];
        flag_val[30]    = (bus.alu_result == 32'h0);
        flag_val[29]    = bus.ex_is_logical ? bus.shifter_carry
                                            : bus.alu_carry;
        flag_val[28]    = bus.ex_is_logical ? fwd[28]
                                            : bus.alu_overflow;
    end

    always_comb begin
        msr_val = fwd;
        for (int i = 0; i < 4; i++) begin
            if (bus.msr_mask[i])
                msr_val[8*i +: 8] = bus.msr_data[8*i +: 8];
        end
    end

    assign new_val = bus.msr_valid ? msr_val : flag_val;
    assign cap     = bus.ex_valid && !bus.flush
                  && (bus.ex_set_cond || bus.msr_valid);

    always_comb begin
        state_d = state_q;
        comm_d  = comm_q;
        pend_d  = pend_q;
        if (!bus.stall) begin
            // An older pending update always commits, even on flush.
            if (state_q == PENDING)
                comm_d = pend_q;
            if (cap) begin
                pend_d  = new_val;
                state_d = PENDING;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= EMPTY;
            comm_q  <= RESET_CPSR;
            pend_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            comm_q  <= comm_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.cpsr           = fwd;
    assign bus.cpsr_committed = comm_q;
    assign bus.flags_pending  = (state_q == PENDING);
endmodule

// File: tb/tb_cpsr_update.sv
// Directed table-driven bench for cpsr_update.
// Checks forwarding, commit latency, stall/flush, MSR masking, reset.
module tb_cpsr_update;
    logic clk;
    logic rst_b;
    int   total;
    int   bad;

    cpsr_update_if bus0 ();
    cpsr_update_if bus1 ();

    cpsr_update #(
        .RESET_CPSR (32'h0000_0000),
        .FWD_EN     (1'b1)
    ) dut0 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus0)
    );

    cpsr_update #(
        .RESET_CPSR (32'h0000_001F),
        .FWD_EN     (1'b0)
    ) dut1 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        K_IDLE,
        K_ARITH,
        K_LOGIC,
        K_MSR,
        K_MSRS,
        K_GHOST
    } kind_t;

    typedef struct {
        kind_t       kind;
        logic [31:0] val;
        logic        c;
        logic        v;
        logic [3:0]  mask;
        logic        stall;
        logic        flush;
        logic [31:0] e_cpsr;
        logic [31:0] e_comm;
        logic        e_pend;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input kind_t k, input logic [31:0] val,
        input logic c, input logic v, input logic [3:0] m,
        input logic st, input logic fl,
        input logic [31:0] ec, input logic [31:0] em,
        input logic ep
    );
        vec_t r;
        r.kind = k;   r.val = val;  r.c = c;  r.v = v;
        r.mask = m;   r.stall = st; r.flush = fl;
        r.e_cpsr = ec; r.e_comm = em; r.e_pend = ep;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle0();
        bus0.ex_valid = 0; bus0.ex_set_cond = 0; bus0.ex_is_logical = 0;
        bus0.alu_result = 0; bus0.alu_carry = 0; bus0.alu_overflow = 0;
        bus0.shifter_carry = 0; bus0.msr_valid = 0; bus0.msr_data = 0;
        bus0.msr_mask = 0; bus0.stall = 0; bus0.flush = 0;
    endtask

    task automatic idle1();
        bus1.ex_valid = 0; bus1.ex_set_cond = 0; bus1.ex_is_logical = 0;
        bus1.alu_result = 0; bus1.alu_carry = 0; bus1.alu_overflow = 0;
        bus1.shifter_carry = 0; bus1.msr_valid = 0; bus1.msr_data = 0;
        bus1.msr_mask = 0; bus1.stall = 0; bus1.flush = 0;
    endtask

    task automatic apply0(input vec_t t);
        idle0();
        bus0.stall = t.stall;
        bus0.flush = t.flush;
        case (t.kind)
            K_ARITH: begin
                bus0.ex_valid = 1; bus0.ex_set_cond = 1;
                bus0.alu_result = t.val;
                bus0.alu_carry = t.c; bus0.alu_overflow = t.v;
            end
            K_LOGIC: begin
                bus0.ex_valid = 1; bus0.ex_set_cond = 1;
                bus0.ex_is_logical = 1; bus0.alu_result = t.val;
                bus0.shifter_carry = t.c;
                bus0.alu_overflow = ~t.v;
            end
            K_MSR: begin
                bus0.ex_valid = 1; bus0.msr_valid = 1;
                bus0.msr_data = t.val; bus0.msr_mask = t.mask;
            end
            K_MSRS: begin
                bus0.ex_valid = 1; bus0.msr_valid = 1;
                bus0.ex_set_cond = 1; bus0.msr_data = t.val;
                bus0.msr_mask = t.mask; bus0.alu_result = 0;
                bus0.alu_carry = 1;
            end
            K_GHOST: begin
                bus0.ex_set_cond = 1; bus0.alu_result = t.val;
                bus0.alu_carry = t.c;
            end
            default: ;
        endcase
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_b = 0;
        idle0();
        idle1();

        vq.push_back(mk(K_IDLE , 32'h0, 0,0,4'h0,0,0, 32'h0000_0000,32'h0000_0000,0));
        vq.push_back(mk(K_ARITH, 32'h0, 1,0,4'h0,0,0, 32'h6000_0000,32'h0000_0000,1));
        vq.push_back(mk(K_IDLE , 32'h0, 0,0,4'h0,0,0, 32'h6000_0000,32'h6000_0000,0));
        vq.push_back(mk(K_IDLE , 32'h0, 0,0,4'h0,0,0, 32'h6000_0000,32'h6000_0000,0));
        vq.push_back(mk(K_ARITH, 32'h8000_0000, 0,1,4'h0,0,0, 32'h9000_0000,32'h6000_0000,1));
        vq.push_back(mk(K_LOGIC, 32'h1, 0,0,4'h0,0,0, 32'h1000_0000,32'h9000_0000,1));
        vq.push_back(mk(K_IDLE , 32'h0, 0,0,4'h0,0,0, 32'h1000_0000,32'h1000_0000,0));
        vq.push_back(mk(K_ARITH, 32'h0, 1,0,4'h0,0,1, 32'h1000_0000,32'h1000_0000,0));
        vq.push_back(mk(K_ARITH, 32'h5, 0,0,4'h0,0,0, 32'h0000_0000,32'h1000_0000,1));
        vq.push_back(mk(K_ARITH, 32'h0, 1,0,4'h0,0,1, 32'h0000_0000,32'h0000_0000,0));
        vq.push_back(mk(K_ARITH, 32'hFFFF_FFFF, 1,0,4'h0,0,0, 32'hA000_0000,32'h0000_0000,1));
        vq.push_back(mk(K_ARITH, 32'h0, 1,0,4'h0,1,0, 32'hA000_0000,32'h0000_0000,1));
        vq.push_back(mk(K_ARITH, 32'h0, 1,0,4'h0,1,0, 32'hA000_0000,32'h0000_0000,1));
        vq.push_back(mk(K_ARITH, 32'h0, 1,0,4'h0,1,0, 32'hA000_0000,32'h0000_0000,1));
        vq.push_back(mk(K_IDLE , 32'h0, 0,0,4'h0,0,0, 32'hA000_0000,32'hA000_0000,0));
        vq.push_back(mk(K_MSR  , 32'h0, 0,0,4'hF,0,0, 32'h0000_0000,32'hA000_0000,1));
        vq.push_back(mk(K_IDLE , 32'h0, 0,0,4'h0,0,0, 32'h0000_0000,32'h0000_0000,0));
        vq.push_back(mk(K_MSR  , 32'hF000_00AA, 0,0,4'h8,0,0, 32'hF000_0000,32'h0000_0000,1));
        vq.push_back(mk(K_IDLE , 32'h0, 0,0,4'h0,0,0, 32'hF000_0000,32'hF000_0000,0));
        vq.push_back(mk(K_MSRS , 32'h0000_0055, 0,0,4'h1,0,0, 32'hF000_0055,32'hF000_0000,1));
        vq.push_back(mk(K_GHOST, 32'h0, 1,0,4'h0,0,0, 32'hF000_0055,32'hF000_0055,0));
        vq.push_back(mk(K_LOGIC, 32'h0, 1,0,4'h0,0,0, 32'h7000_0055,32'hF000_0055,1));
        vq.push_back(mk(K_IDLE , 32'h0, 0,0,4'h0,0,0, 32'h7000_0055,32'h7000_0055,0));

        repeat (2) @(posedge clk);
        #1;
        check("rst0_cpsr", bus0.cpsr, 32'h0);
        check("rst0_comm", bus0.cpsr_committed, 32'h0);
        check("rst0_pend", {31'h0, bus0.flags_pending}, 32'h0);
        check("rst1_cpsr", bus1.cpsr, 32'h0000_001F);
        rst_b = 1;

        for (int i = 0; i < vq.size(); i++) begin
            apply0(vq[i]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_cpsr", i), bus0.cpsr, vq[i].e_cpsr);
            check($sformatf("v%0d_comm", i), bus0.cpsr_committed,
                  vq[i].e_comm);
            check($sformatf("v%0d_pend", i),
                  {31'h0, bus0.flags_pending}, {31'h0, vq[i].e_pend});
        end

        // Reset while an update is pending: it must be discarded.
        apply0(mk(K_ARITH, 32'h0, 1,0,4'h0,0,0, 32'h0,32'h0,0));
        @(posedge clk);
        #1;
        check("prerst_cpsr", bus0.cpsr, 32'h6000_0055);
        check("prerst_pend", {31'h0, bus0.flags_pending}, 32'h1);
        idle0();
        #2;
        rst_b = 0;
        #1;
        check("midrst_cpsr", bus0.cpsr, 32'h0);
        check("midrst_comm", bus0.cpsr_committed, 32'h0);
        check("midrst_pend", {31'h0, bus0.flags_pending}, 32'h0);
        @(posedge clk);
        #1;
        rst_b = 1;
        @(posedge clk);
        #1;
        check("postrst_comm", bus0.cpsr_committed, 32'h0);
        check("postrst_pend", {31'h0, bus0.flags_pending}, 32'h0);

        // No forwarding: cpsr follows the committed copy only.
        bus1.ex_valid = 1;
        bus1.ex_set_cond = 1;
        bus1.alu_result = 32'h0;
        bus1.alu_carry = 1;
        @(posedge clk);
        #1;
        idle1();
        check("nf1_cpsr", bus1.cpsr, 32'h0000_001F);
        check("nf1_comm", bus1.cpsr_committed, 32'h0000_001F);
        check("nf1_pend", {31'h0, bus1.flags_pending}, 32'h1);
        @(posedge clk);
        #1;
        check("nf2_cpsr", bus1.cpsr, 32'h6000_001F);
        check("nf2_comm", bus1.cpsr_committed, 32'h6000_001F);
        check("nf2_pend", {31'h0, bus1.flags_pending}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
